// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, flag bit positions and the opcode legality check
// for the alu issue sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  localparam int ZCV_Z = 2;
  localparam int ZCV_C = 1;
  localparam int ZCV_V = 0;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO with occupancy count; the read port shows zero while empty
// so downstream outputs read as zero after reset.
module alu_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of a registered alu: input FIFO, credit-gated issue,
// tag/err shift pipe and in-order output FIFO. Optional ALU_SEQ_PERF_EN adds counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int ALU_LAT   = 1,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_zcv,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_SEQ_PERF_EN
  output logic [31:0]      perf_issued,
  output logic [15:0]      perf_illegal,
`endif
  output logic             out_err
);

  localparam int IN_W  = 32 + 32 + 4 + TAG_W;
  localparam int OUT_W = 32 + 3 + TAG_W + 1;

  logic                        ready_q;
  logic                        in_full;
  logic                        in_empty;
  logic [IN_W-1:0]             in_head;
  logic [$clog2(IN_DEPTH):0]   in_count;
  logic                        out_full;
  logic                        out_empty;
  logic [OUT_W-1:0]            out_head;
  logic [OUT_W-1:0]            out_wdata;
  logic [$clog2(OUT_DEPTH):0]  out_count;
  logic                        unused_sigs;

  logic [31:0]      head_src1;
  logic [31:0]      head_src2;
  logic [3:0]       head_op;
  logic [TAG_W-1:0] head_tag;
  logic             head_legal;
  logic [7:0]       inflight;
  logic             credit_ok;
  logic             issue;

  logic [31:0]      alu_src1_q, alu_src1_d;
  logic [31:0]      alu_src2_q, alu_src2_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [ALU_LAT:0] vld_q;
  logic [ALU_LAT:0] err_q;
  logic [TAG_W-1:0] tag_q [ALU_LAT+1];
  logic [2:0]       cap_zcv;

  assign in_ready = ready_q & ~in_full;

  alu_seq_fifo #(.WIDTH(IN_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid & in_ready),
    .wdata_i ({in_src1, in_src2, in_op, in_tag}),
    .pop_i   (issue),
    .rdata_o (in_head),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_count)
  );

  assign head_src1  = in_head[IN_W-1 -: 32];
  assign head_src2  = in_head[TAG_W+4 +: 32];
  assign head_op    = in_head[TAG_W +: 4];
  assign head_tag   = in_head[TAG_W-1:0];
  assign head_legal = is_legal_op(head_op);

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ALU_LAT; i++) inflight = inflight + 8'(vld_q[i]);
  end

  // Credit counts every result already owed a slot; a same-cycle pop frees nothing.
  assign credit_ok = (32'(out_count) + 32'(inflight)) < $unsigned(OUT_DEPTH);
  assign issue     = ~in_empty & credit_ok;

  always_comb begin
    alu_src1_d = alu_src1_q;
    alu_src2_d = alu_src2_q;
    alu_ctrl_d = alu_ctrl_q;
    if (issue && head_legal) begin
      alu_src1_d = head_src1;
      alu_src2_d = head_src2;
      alu_ctrl_d = head_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      alu_src1_q <= '0;
      alu_src2_q <= '0;
      alu_ctrl_q <= '0;
      vld_q      <= '0;
      err_q      <= '0;
      for (int i = 0; i <= ALU_LAT; i++) tag_q[i] <= '0;
    end else begin
      ready_q    <= 1'b1;
      alu_src1_q <= alu_src1_d;
      alu_src2_q <= alu_src2_d;
      alu_ctrl_q <= alu_ctrl_d;
      vld_q[0]   <= issue;
      err_q[0]   <= issue & ~head_legal;
      tag_q[0]   <= head_tag;
      for (int i = 1; i <= ALU_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign alu_src1 = alu_src1_q;
  assign alu_src2 = alu_src2_q;
  assign alu_ctrl = alu_ctrl_q;

  always_comb begin
    cap_zcv        = '0;
    cap_zcv[ZCV_Z] = alu_zero;
    cap_zcv[ZCV_C] = alu_cout;
    cap_zcv[ZCV_V] = alu_overflow;
  end

  assign out_wdata = err_q[ALU_LAT] ? {32'd0, 3'b000, tag_q[ALU_LAT], 1'b1}
                                    : {alu_result, cap_zcv, tag_q[ALU_LAT], 1'b0};

  alu_seq_fifo #(.WIDTH(OUT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (vld_q[ALU_LAT]),
    .wdata_i (out_wdata),
    .pop_i   (out_ready),
    .rdata_o (out_head),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  assign out_valid  = ~out_empty;
  assign out_result = out_head[OUT_W-1 -: 32];
  assign out_zcv    = out_head[TAG_W+1 +: 3];
  assign out_tag    = out_head[1 +: TAG_W];
  assign out_err    = out_head[0];

  assign unused_sigs = ^{in_count, out_full};

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [15:0] perf_illegal_q, perf_illegal_d;

  always_comb begin
    perf_issued_d  = perf_issued_q;
    perf_illegal_d = perf_illegal_q;
    if (issue) begin
      perf_issued_d = perf_issued_q + 32'd1;
      if (!head_legal) perf_illegal_d = perf_illegal_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q  <= '0;
      perf_illegal_q <= '0;
    end else begin
      perf_issued_q  <= perf_issued_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural
// single-stage registered alu attached to the issue port.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [3:0]  in_op;
  logic [3:0]  in_tag;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_cout;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_zcv;
  logic [3:0]  out_tag;
  logic        out_err;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_issued;
  logic [15:0] perf_illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_src1      (in_src1),
    .in_src2      (in_src2),
    .in_op        (in_op),
    .in_tag       (in_tag),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zcv      (out_zcv),
    .out_tag      (out_tag),
`ifdef ALU_SEQ_PERF_EN
    .perf_issued  (perf_issued),
    .perf_illegal (perf_illegal),
`endif
    .out_err      (out_err)
  );

  // Behavioural alu: {result, zero, cout, overflow}; subtraction carry means no borrow.
  function automatic logic [34:0] aluEval(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd6: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: r = '0;
    endcase
    return {r, (r == 32'd0), c, v};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {alu_result, alu_zero, alu_cout, alu_overflow} <= '0;
    else        {alu_result, alu_zero, alu_cout, alu_overflow} <= aluEval(alu_src1, alu_src2, alu_ctrl);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input logic [3:0] tag);
    in_valid = v;
    in_src1  = a;
    in_src2  = b;
    in_op    = op;
    in_tag   = tag;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int recv;
    int bad;
    logic acc;
    logic pop;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_alu_src1", alu_src1, 0);
    checkOutput("rst_alu_ctrl", alu_ctrl, 0);
    checkOutput("rst_out_result", out_result, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_release", in_ready, 1);

    // ADD overflow, latency of three edges
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 4'd3);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("add_valid_e0", out_valid, 0);
    tick();
    tick();
    checkOutput("add_valid_e2", out_valid, 0);
    tick();
    checkOutput("add_valid_e3", out_valid, 1);
    checkOutput("add_result", out_result, 64'h8000_0000);
    checkOutput("add_zcv", out_zcv, 3'b001);
    checkOutput("add_tag", out_tag, 3);
    checkOutput("add_err", out_err, 0);
    checkOutput("add_alu_src1", alu_src1, 64'h7FFF_FFFF);
    checkOutput("add_alu_ctrl", alu_ctrl, 2);
    tick();
    checkOutput("add_popped", out_valid, 0);

    // SUB then SLT back to back
    applyStimulus(1'b1, 32'd5, 32'd5, OP_SUB, 4'd4);
    tick();
    applyStimulus(1'b1, 32'd1, 32'd2, OP_SLT, 4'd5);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    tick();
    checkOutput("sub_valid_e2", out_valid, 0);
    tick();
    checkOutput("sub_valid", out_valid, 1);
    checkOutput("sub_result", out_result, 0);
    checkOutput("sub_zcv", out_zcv, 3'b110);
    checkOutput("sub_tag", out_tag, 4);
    tick();
    checkOutput("slt_valid", out_valid, 1);
    checkOutput("slt_result", out_result, 1);
    checkOutput("slt_zcv", out_zcv, 3'b000);
    checkOutput("slt_tag", out_tag, 5);
    tick();
    checkOutput("slt_popped", out_valid, 0);

    // Illegal opcode between two ANDs
    bad = 0;
    applyStimulus(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 4'd0);
    tick();
    if (alu_ctrl == 4'd3) bad++;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd3, 4'd1);
    tick();
    if (alu_ctrl == 4'd3) bad++;
    applyStimulus(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, OP_AND, 4'd2);
    tick();
    if (alu_ctrl == 4'd3) bad++;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    tick();
    if (alu_ctrl == 4'd3) bad++;
    checkOutput("and0_valid", out_valid, 1);
    checkOutput("and0_result", out_result, 64'hF000_F000);
    checkOutput("and0_zcv", out_zcv, 3'b000);
    checkOutput("and0_tag", out_tag, 0);
    checkOutput("and0_err", out_err, 0);
    tick();
    if (alu_ctrl == 4'd3) bad++;
    checkOutput("ill_valid", out_valid, 1);
    checkOutput("ill_result", out_result, 0);
    checkOutput("ill_zcv", out_zcv, 3'b000);
    checkOutput("ill_tag", out_tag, 1);
    checkOutput("ill_err", out_err, 1);
    tick();
    if (alu_ctrl == 4'd3) bad++;
    checkOutput("and2_result", out_result, 0);
    checkOutput("and2_zcv", out_zcv, 3'b100);
    checkOutput("and2_tag", out_tag, 2);
    checkOutput("and2_err", out_err, 0);
    tick();
    if (alu_ctrl == 4'd3) bad++;
    checkOutput("ill_never_on_ctrl", bad, 0);
    checkOutput("ill_drained", out_valid, 0);

    // Backpressure: 12 offered with out_ready low
    out_ready = 1'b0;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(sent < 12, 32'(sent), 32'd100, OP_ADD, 4'(sent));
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    checkOutput("bp_accepted", sent, 8);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      applyStimulus(sent < 12, 32'(sent), 32'd100, OP_ADD, 4'(sent));
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        checkOutput("bp_order_tag", out_tag, 64'(recv));
        checkOutput("bp_order_result", out_result, 64'(100 + recv));
        recv++;
      end
      tick();
      if (acc) sent++;
    end
    checkOutput("bp_all_sent", sent, 12);
    checkOutput("bp_all_returned", recv, 12);
    checkOutput("bp_drained", out_valid, 0);

    // Throughput: 16 back to back, out_valid high from cycle 3 for 16 cycles
    bad = 0;
    for (int c = 0; c < 22; c++) begin
      applyStimulus(c < 16, 32'(c), 32'h100, OP_OR, 4'(c));
      if (c < 16 && !in_ready) bad++;
      tick();
      checkOutput("tp_valid", out_valid, (c >= 3 && c <= 18) ? 64'd1 : 64'd0);
      if (c >= 3 && c <= 18) begin
        checkOutput("tp_tag", out_tag, 64'(c - 3));
        checkOutput("tp_result", out_result, 64'(32'h100 + 32'(c - 3)));
      end
    end
    checkOutput("tp_ready_held", bad, 0);

    // Reset with five requests buffered or in flight
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 32'h1234 + 32'(c), 32'h10, OP_ADD, 4'(9 + c));
      tick();
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    tick();
    tick();
    checkOutput("mid_pre_valid", out_valid, 1);
    checkOutput("mid_pre_alu_src1", alu_src1, 64'h1237);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    checkOutput("mid_rst_alu_src1", alu_src1, 0);
    checkOutput("mid_rst_alu_src2", alu_src2, 0);
    checkOutput("mid_rst_alu_ctrl", alu_ctrl, 0);
    checkOutput("mid_rst_out_result", out_result, 0);
    checkOutput("mid_rst_out_zcv", out_zcv, 0);
    checkOutput("mid_rst_out_tag", out_tag, 0);
    checkOutput("mid_rst_out_err", out_err, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) bad++;
    end
    checkOutput("mid_no_stale", bad, 0);
    checkOutput("mid_ready_back", in_ready, 1);

    // Fresh request after recovery
    applyStimulus(1'b1, 32'd2, 32'd3, OP_ADD, 4'd7);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    tick();
    tick();
    tick();
    checkOutput("post_valid", out_valid, 1);
    checkOutput("post_result", out_result, 5);
    checkOutput("post_tag", out_tag, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue stage directly upstream of the registered 32-bit alu (ports clk, rst_n, src1, src2, ALU_control, result, zero, cout, overflow).
- Accepts operation requests over a valid/ready handshake and buffers them in an input FIFO.
- Drives one operation per cycle into the alu, then captures result plus zero/cout/overflow in order into an output FIFO.
- Screens illegal opcodes and provides end-to-end backpressure, so no result is ever lost.

Parameters:
- IN_DEPTH, 4, input FIFO entries (power of two, ≥2).
- OUT_DEPTH, 4, output FIFO entries (power of two, ≥ALU_LAT+2).
- ALU_LAT, 1, alu register stages between operand sampling and result.
- TAG_W, 4, width of the user tag carried with each request.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a rising edge.
- in_src1  in  32  operand 1.
- in_src2  in  32  operand 2.
- in_op  in  4  opcode.
- in_tag  in  TAG_W  user tag.
- alu_src1  out  32  to alu src1, registered.
- alu_src2  out  32  to alu src2, registered.
- alu_ctrl  out  4  to alu ALU_control, registered.
- alu_result  in  32  from alu result.
- alu_zero  in  1  from alu zero.
- alu_cout  in  1  from alu cout.
- alu_overflow  in  1  from alu overflow.
- out_valid  out  1  response valid.
- out_ready  in  1  response consumed when out_valid & out_ready at a rising edge.
- out_result  out  32  result.
- out_zcv  out  3  {zero, cout, overflow}.
- out_tag  out  TAG_W  echoed tag.
- out_err  out  1  request had an illegal opcode.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both FIFOs emptied; in-flight pipeline cleared.
  - in_ready=0 during reset, 1 from the first edge after release.
  - out_valid=0; out_result, out_zcv, out_tag, out_err = 0.
  - alu_src1, alu_src2, alu_ctrl = 0.
- Reset mid-operation: all buffered and in-flight operations are dropped silently, with no partial response.
- Legal opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR. Every other value is illegal.
- Input FIFO:
  - in_ready = not full.
  - Simultaneous push and pop when full is not allowed: in_ready is already 0 when full.
  - Push and pop in the same cycle when non-empty is allowed; count is unchanged.
- Issue:
  - An issue occurs on an edge where the input FIFO is non-empty and credit = OUT_DEPTH − out_count − inflight > 0.
  - Both out_count and inflight are sampled at the start of the cycle; a same-cycle output pop gives no credit.
  - On issue, alu_src1/alu_src2/alu_ctrl load the head entry, and {valid, tag, err} enters a shift pipe of length ALU_LAT+1.
  - For an illegal op, the alu_* registers are not updated: they hold their previous values, and err=1 travels down the pipe.
  - With no issue, the alu_* registers hold their values.
- Capture:
  - The pipe's last stage is valid ALU_LAT+1 edges after issue; at that edge the output FIFO pushes.
  - Pushed entry: {alu_result, {alu_zero, alu_cout, alu_overflow}, tag, 0}, or {0, 000, tag, 1} when err.
  - Order is preserved, illegal ops included.
- Output FIFO:
  - out_* show the head entry; out_valid = not empty.
  - Push never meets a full FIFO; this is guaranteed by credit.
  - Push and pop in the same cycle are allowed.
- Latency: from the acceptance edge E, the response is visible after edge E+ALU_LAT+2 (E+3 by default) when the FIFOs are empty and out_ready=1.
- Throughput: one response per cycle sustained when out_ready=1.
- inflight counts the valid bits in the pipe, range 0..ALU_LAT+1.

Optional Feature:
- ALU_SEQ_PERF_EN defined:
  - Adds output ports perf_issued (32) and perf_illegal (16).
  - Both reset to 0 and wrap on overflow.
  - perf_issued increments on every issue; perf_illegal also increments on each illegal issue.
- Not defined: the ports and counters are absent. Functional behaviour is identical in both cases.

Decomposition:
- Package alu_seq_pkg:
  - Opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR.
  - ZCV bit indices ZCV_Z=2, ZCV_C=1, ZCV_V=0.
  - Function is_legal_op.
- Sub-module alu_seq_fifo (WIDTH, DEPTH; push/pop/full/empty/count, asynchronous active-low reset), instantiated twice: input and output.

Test Plan (bench instantiates the real alu; each line is stimulus -> required response):
- ADD src1=0x7FFFFFFF, src2=0x00000001, tag 3 -> out_result 0x80000000, out_zcv 001, out_tag 3, out_err 0, out_valid 3 cycles after acceptance.
- SUB 5−5, then SLT 1<2, back to back -> 0x00000000 zcv 110, then 0x00000001, both in issue order on consecutive cycles.
- Illegal op 4'd3 (tag 1) sandwiched between two ANDs (tags 0, 2) -> tags 0,1,2 returned in order; tag 1 has out_err 1, result 0, zcv 000; alu_ctrl never shows 3.
- out_ready=0 while 12 requests are offered -> exactly 8 accepted (4 output + 4 input), then in_ready=0; release out_ready -> all 12 returned in order, none lost or duplicated.
- 16 back-to-back requests with out_ready=1 -> out_valid high 16 consecutive cycles starting at cycle 3.
- rst_n pulsed low with 5 requests buffered or in flight -> out_valid drops immediately, all alu_* and out_* read 0, and no stale response appears after release.
